// File: rtl/sram_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter_pkg
// Shared definitions for the SRAM-like request arbiter:
//   - SRAM-like field widths (size, byte strobes, address, data)
//   - master ID encoding used in the ownership FIFO
//   - arbiter FSM state encoding
// ---------------------------------------------------------------------------
package sram_req_arbiter_pkg;

    localparam int SIZE_W = 2;
    localparam int STRB_W = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Which master owns a transaction.
    typedef enum logic {
        MST_INST = 1'b0,
        MST_DATA = 1'b1
    } mst_e;

    // IDLE: grant is decided combinationally each cycle.
    // HOLD: a request is mid-handshake and the grant is frozen.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/sram_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter_if
// One SRAM-like request/response port.
//   master modport : drives req/wr/size/wstrb/addr/wdata,
//                    receives addr_ok/data_ok/rdata
//   slave modport  : the mirror image
// ---------------------------------------------------------------------------
interface sram_req_arbiter_if;
    import sram_req_arbiter_pkg::*;

    logic              req;
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_req_arbiter_owner_fifo.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter_owner_fifo
// In-order FIFO of master IDs, one entry per accepted transaction.
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   push, push_id  enqueue the owner of a newly accepted request
//   pop            dequeue the head on a completed transaction
//   head           owner of the oldest outstanding transaction
//   count          occupancy (explicit counter, 0..DEPTH)
//   full, empty    occupancy flags
// ---------------------------------------------------------------------------
module sram_req_arbiter_owner_fifo
    import sram_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  mst_e                   push_id,
    input  logic                   pop,
    output mst_e                   head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    mst_e             mem_q [DEPTH];
    mst_e             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Guard locally so a misbehaving caller cannot corrupt the count.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;   // wraps modulo DEPTH
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;          // idle, or push+pop together
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= MST_INST;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
// Shares one SRAM-like slave port between the instruction master (m0) and
// the data master (m1). Data wins by default; after STARVE_LIMIT consecutive
// data grants while m0 is waiting, m0 is granted once. Each accepted request
// records its owner in an in-order FIFO so completions are routed back.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   m0            instruction master port (slave modport)
//   m1            data master port (slave modport)
//   s             bridge-side port (master modport)
//   outstanding   number of accepted but uncompleted transactions
//   err_spurious  sticky: a completion arrived with nothing outstanding
// ---------------------------------------------------------------------------
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    sram_req_arbiter_if.slave      m0,
    sram_req_arbiter_if.slave      m1,
    sram_req_arbiter_if.master     s,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   err_spurious
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    state_e           state_q, state_d;
    mst_e             hold_id_q, hold_id_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             err_q, err_d;

    logic grant_vld, grant_on, pending, s_req_int, hs, pop;
    mst_e grant_id;
    mst_e head;
    logic full, empty;

    // Grant selection. HOLD pins the grant so the slave never sees the
    // request switch masters before addr_ok.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = MST_INST;
        if (state_q == HOLD) begin
            grant_vld = 1'b1;
            grant_id  = hold_id_q;
        end else if (starve_q == STARVE_MAX && m0.req) begin
            grant_vld = 1'b1;
            grant_id  = MST_INST;
        end else if (m1.req) begin
            grant_vld = 1'b1;
            grant_id  = MST_DATA;
        end else if (m0.req) begin
            grant_vld = 1'b1;
            grant_id  = MST_INST;
        end
    end

    // resetn gates the grant so every output is quiet while in reset.
    assign grant_on  = resetn && grant_vld;
    assign pending   = (grant_id == MST_DATA) ? m1.req : m0.req;
    assign s_req_int = grant_on && pending && !full;
    assign hs        = s_req_int && s.addr_ok;

    // Slave-side request fields follow the granted master, zero otherwise.
    always_comb begin
        s.req   = s_req_int;
        s.wr    = 1'b0;
        s.size  = '0;
        s.wstrb = '0;
        s.addr  = '0;
        s.wdata = '0;
        if (grant_on) begin
            if (grant_id == MST_DATA) begin
                s.wr    = m1.wr;
                s.size  = m1.size;
                s.wstrb = m1.wstrb;
                s.addr  = m1.addr;
                s.wdata = m1.wdata;
            end else begin
                s.wr    = m0.wr;
                s.size  = m0.size;
                s.wstrb = m0.wstrb;
                s.addr  = m0.addr;
                s.wdata = m0.wdata;
            end
        end
    end

    assign m0.addr_ok = hs && (grant_id == MST_INST);
    assign m1.addr_ok = hs && (grant_id == MST_DATA);

    // Completions go to the FIFO head; nothing is routed when it is empty.
    assign pop        = s.data_ok && !empty;
    assign m0.data_ok = pop && (head == MST_INST);
    assign m1.data_ok = pop && (head == MST_DATA);
    assign m0.rdata   = m0.data_ok ? s.rdata : '0;
    assign m1.rdata   = m1.data_ok ? s.rdata : '0;

    sram_req_arbiter_owner_fifo #(
        .DEPTH (DEPTH)
    ) u_owner_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (hs),
        .push_id (grant_id),
        .pop     (pop),
        .head    (head),
        .count   (outstanding),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_d   = state_q;
        hold_id_d = hold_id_q;
        starve_d  = starve_q;
        err_d     = err_q || (s.data_ok && empty);

        case (state_q)
            IDLE: begin
                if (s_req_int && !s.addr_ok) begin
                    state_d   = HOLD;
                    hold_id_d = grant_id;
                end
            end
            HOLD: begin
                // Also release if the held master withdraws, so the
                // arbiter cannot lock up on a protocol violation.
                if (hs || !pending) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!m0.req) begin
            starve_d = '0;
        end else if (hs && grant_id == MST_INST) begin
            starve_d = '0;
        end else if (hs && grant_id == MST_DATA && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            hold_id_q <= MST_INST;
            starve_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_id_q <= hold_id_d;
            starve_q  <= starve_d;
            err_q     <= err_d;
        end
    end

    assign err_spurious = err_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_req_arbiter
// Self-checking bench for sram_req_arbiter (DEPTH=4, STARVE_LIMIT=3).
// The bench plays both masters and the slave. Expected owners are queued
// when a request is expected to be accepted and popped when the bench
// drives the matching completion.
// ---------------------------------------------------------------------------
module tb_sram_req_arbiter;
    import sram_req_arbiter_pkg::*;

    logic       clk;
    logic       resetn;
    logic [2:0] outstanding;
    logic       err_spurious;

    sram_req_arbiter_if m0_if ();
    sram_req_arbiter_if m1_if ();
    sram_req_arbiter_if s_if ();

    sram_req_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (3)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .m0           (m0_if),
        .m1           (m1_if),
        .s            (s_if),
        .outstanding  (outstanding),
        .err_spurious (err_spurious)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    mst_e exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the current completion against the scoreboard head.
    task automatic chk_ret(input logic [31:0] rd);
        mst_e e;
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("ret_m0_dok", m0_if.data_ok, e == MST_INST);
            check("ret_m1_dok", m1_if.data_ok, e == MST_DATA);
            check("ret_m0_rdata", m0_if.rdata, (e == MST_INST) ? rd : 32'h0);
            check("ret_m1_rdata", m1_if.rdata, (e == MST_DATA) ? rd : 32'h0);
        end
    endtask

    task automatic ret(input logic [31:0] rd);
        s_if.data_ok = 1'b1;
        s_if.rdata   = rd;
        #1;
        chk_ret(rd);
        tick();
        s_if.data_ok = 1'b0;
        s_if.rdata   = '0;
    endtask

    task automatic idle_inputs();
        m0_if.req = 0; m0_if.wr = 0; m0_if.size = 0; m0_if.wstrb = 0; m0_if.addr = 0; m0_if.wdata = 0;
        m1_if.req = 0; m1_if.wr = 0; m1_if.size = 0; m1_if.wstrb = 0; m1_if.addr = 0; m1_if.wdata = 0;
        s_if.addr_ok = 0; s_if.data_ok = 0; s_if.rdata = 0;
    endtask

    bit          seq [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
    logic [31:0] rd;

    initial begin
        resetn = 1'b0;
        idle_inputs();

        // Everything quiet while in reset, even with active inputs.
        m0_if.req = 1; m1_if.req = 1; m1_if.addr = 32'h55; s_if.addr_ok = 1;
        s_if.data_ok = 1; s_if.rdata = 32'hFFFF;
        repeat (2) tick();
        check("rst_s_req", s_if.req, 0);
        check("rst_s_addr", s_if.addr, 0);
        check("rst_m1_aok", m1_if.addr_ok, 0);
        check("rst_m0_dok", m0_if.data_ok, 0);
        check("rst_m1_rdata", m1_if.rdata, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_spurious, 0);
        idle_inputs();
        tick();
        resetn = 1'b1;
        tick();

        // Data wins a simultaneous request; completion returns to m1.
        m0_if.req = 1; m0_if.addr = 32'h1000;
        m1_if.req = 1; m1_if.addr = 32'h2000; m1_if.wr = 1; m1_if.wdata = 32'hCAFE_0001;
        m1_if.wstrb = 4'hF; m1_if.size = 2'd2;
        s_if.addr_ok = 1;
        #1;
        check("prio_s_req", s_if.req, 1);
        check("prio_m1_aok", m1_if.addr_ok, 1);
        check("prio_m0_aok", m0_if.addr_ok, 0);
        check("prio_s_addr", s_if.addr, 32'h2000);
        check("prio_s_wr", s_if.wr, 1);
        check("prio_s_wdata", s_if.wdata, 32'hCAFE_0001);
        check("prio_s_wstrb", s_if.wstrb, 4'hF);
        exp_q.push_back(MST_DATA);
        tick();
        idle_inputs();
        #1;
        check("prio_outstanding", outstanding, 1);
        ret(32'h1234_5678);
        #1;
        check("prio_drained", outstanding, 0);

        // HOLD: m0 waits on addr_ok while m1 starts requesting.
        m0_if.req = 1; m0_if.addr = 32'h3000;
        #1;
        check("hold_c1_s_req", s_if.req, 1);
        check("hold_c1_s_addr", s_if.addr, 32'h3000);
        check("hold_c1_m0_aok", m0_if.addr_ok, 0);
        tick();
        m1_if.req = 1; m1_if.addr = 32'h4000;
        for (int c = 2; c <= 3; c++) begin
            #1;
            check("hold_s_addr", s_if.addr, 32'h3000);
            check("hold_m1_aok", m1_if.addr_ok, 0);
            tick();
        end
        s_if.addr_ok = 1;
        #1;
        check("hold_m0_aok", m0_if.addr_ok, 1);
        check("hold_m1_aok_end", m1_if.addr_ok, 0);
        exp_q.push_back(MST_INST);
        tick();
        m0_if.req = 0;
        #1;
        check("hold_next_m1_aok", m1_if.addr_ok, 1);
        check("hold_next_s_addr", s_if.addr, 32'h4000);
        exp_q.push_back(MST_DATA);
        tick();
        idle_inputs();
        ret(32'hA0A0_0001);
        ret(32'hB0B0_0002);

        // Starvation guard with back-to-back push and pop.
        for (int i = 0; i < 8; i++) begin
            m0_if.req = 1; m1_if.req = 1;
            m0_if.addr = 32'h100 + i; m1_if.addr = 32'h200 + i;
            s_if.addr_ok = 1;
            s_if.data_ok = (i > 0);
            rd = $urandom;
            s_if.rdata = rd;
            #1;
            check("starve_m1_aok", m1_if.addr_ok, seq[i]);
            check("starve_m0_aok", m0_if.addr_ok, !seq[i]);
            check("starve_s_addr", s_if.addr, seq[i] ? 32'h200 + i : 32'h100 + i);
            if (i > 0) chk_ret(rd);
            exp_q.push_back(seq[i] ? MST_DATA : MST_INST);
            tick();
        end
        idle_inputs();
        #1;
        check("starve_outstanding", outstanding, 1);
        ret($urandom);

        // Fill to DEPTH, then free one slot.
        for (int i = 0; i < 4; i++) begin
            m0_if.req = (i % 2 == 0); m1_if.req = (i % 2 != 0);
            s_if.addr_ok = 1;
            #1;
            check("fill_aok", (i % 2 == 0) ? m0_if.addr_ok : m1_if.addr_ok, 1);
            exp_q.push_back((i % 2 == 0) ? MST_INST : MST_DATA);
            tick();
        end
        m0_if.req = 0; m1_if.req = 1; m1_if.addr = 32'h900;
        #1;
        check("full_outstanding", outstanding, 4);
        check("full_s_req", s_if.req, 0);
        check("full_m1_aok", m1_if.addr_ok, 0);
        tick();
        check("full_s_req_held", s_if.req, 0);
        s_if.data_ok = 1; s_if.rdata = 32'h0F0F_0001;
        #1;
        check("full_pop_same_cycle_s_req", s_if.req, 0);
        chk_ret(32'h0F0F_0001);
        tick();
        s_if.data_ok = 0; s_if.rdata = 0;
        #1;
        check("full_after_pop_outstanding", outstanding, 3);
        check("full_after_pop_s_req", s_if.req, 1);
        check("full_after_pop_m1_aok", m1_if.addr_ok, 1);
        exp_q.push_back(MST_DATA);
        tick();
        idle_inputs();
        #1;
        check("refill_outstanding", outstanding, 4);
        for (int i = 0; i < 4; i++) ret(32'h5000_0000 + i);
        #1;
        check("drain_outstanding", outstanding, 0);

        // Spurious completion, then async reset mid-cycle.
        s_if.data_ok = 1; s_if.rdata = 32'hDEAD;
        #1;
        check("spur_m0_dok", m0_if.data_ok, 0);
        check("spur_m1_dok", m1_if.data_ok, 0);
        check("spur_m0_rdata", m0_if.rdata, 0);
        check("spur_m1_rdata", m1_if.rdata, 0);
        tick();
        s_if.data_ok = 0; s_if.rdata = 0;
        #1;
        check("spur_err_set", err_spurious, 1);
        tick();
        check("spur_err_held", err_spurious, 1);
        m1_if.req = 1; s_if.addr_ok = 1;
        #1;
        check("pre_rst_m1_aok", m1_if.addr_ok, 1);
        tick();
        idle_inputs();
        #1;
        check("pre_rst_outstanding", outstanding, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_outstanding", outstanding, 0);
        check("async_rst_err", err_spurious, 0);
        exp_q.delete();
        tick();
        resetn = 1'b1;
        tick();
        s_if.data_ok = 1; s_if.rdata = 32'hBEEF;
        #1;
        check("post_rst_m1_dok", m1_if.data_ok, 0);
        check("post_rst_m0_dok", m0_if.data_ok, 0);
        tick();
        s_if.data_ok = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
